sms4_rk_reverse_buf: RTL and testbench

Round-key buffer for the SMS4 core. It sits between the key-expansion datapath (the writer, whose L' transform includes the <<<23 rotate) and the round datapath (the reader). It captures the 32 round keys rk0..rk31 as the expansion produces them. It then replays them on demand: in forward order for encryption, or in reverse order (rk31..rk0) for decryption.

---
 rtl/sms4_rk_reverse_buf_if.sv | 33 +++
 rtl/sms4_rk_reverse_buf.sv | 120 ++++++++++++
 tb/tb_sms4_rk_reverse_buf.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/sms4_rk_reverse_buf_if.sv
// rtl/sms4_rk_reverse_buf_if.sv - round-key write/read bus between key expansion, key buffer and round datapath
//
// Signals:
//   rk_wr_valid/rk_wr_ready/rk_wr_data  writer handshake, keys presented rk0 first
//   dec                                 read order select (0 forward, 1 reverse)
//   rk_rd_req                           reader asks for the next key
//   rk_rd_valid/rk_rd_data/rk_rd_idx    served key and its round number
//   loaded                              all round keys are held
// Modports: master = key expansion + round datapath side, slave = key buffer.

interface sms4_rk_reverse_buf_if #(
    parameter int BWIDTH = 32
);
    logic                rk_wr_valid;
    logic                rk_wr_ready;
    logic [0:BWIDTH-1]   rk_wr_data;
    logic                dec;
    logic                rk_rd_req;
    logic                rk_rd_valid;
    logic [0:BWIDTH-1]   rk_rd_data;
    logic [4:0]          rk_rd_idx;
    logic                loaded;

    modport master (
        output rk_wr_valid, rk_wr_data, dec, rk_rd_req,
        input  rk_wr_ready, rk_rd_valid, rk_rd_data, rk_rd_idx, loaded
    );

    modport slave (
        input  rk_wr_valid, rk_wr_data, dec, rk_rd_req,
        output rk_wr_ready, rk_rd_valid, rk_rd_data, rk_rd_idx, loaded
    );
endinterface

// File: rtl/sms4_rk_reverse_buf.sv
// rtl/sms4_rk_reverse_buf.sv - SMS4 round-key capture buffer with forward/reverse replay
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   clear  synchronous flush back to LOAD (storage left stale)
//   bus    sms4_rk_reverse_buf_if.slave: write side, read side, dec, loaded
// Keys pass through untouched; bit 0 of each key is its MSB.

module sms4_rk_reverse_buf #(
    parameter int BWIDTH = 32,
    parameter int NROUND = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    sms4_rk_reverse_buf_if.slave  bus
);

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [0:BWIDTH-1] mem [0:NROUND-1];
    logic [4:0]        wr_cnt;
    logic [4:0]        rd_cnt;
    logic              dec_lat;

    logic              wr_fire;
    logic              rd_fire;
    logic              rd_rev;
    logic [4:0]        rd_addr;

    assign wr_fire = bus.rk_wr_valid & bus.rk_wr_ready;
    assign rd_fire = bus.rk_rd_req & (state == ST_READY);

    // The first request of a block samples dec live and uses it at once;
    // the rest of the block follows the latched copy.
    assign rd_rev  = (rd_cnt == 5'd0) ? bus.dec : dec_lat;
    assign rd_addr = rd_rev ? (5'd31 - rd_cnt) : rd_cnt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: begin
                if (wr_fire && (wr_cnt == 5'd31)) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                state_nxt = ST_READY;
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
        if (clear) begin
            state_nxt = ST_LOAD;
        end
    end

    // State-decoded outputs
    always_comb begin
        bus.rk_wr_ready = (state == ST_LOAD);
        bus.loaded      = (state == ST_READY);
    end

    // Key storage, deliberately without reset
    always_ff @(posedge clk) begin
        if (wr_fire && !clear) begin
            mem[wr_cnt] <= bus.rk_wr_data;
        end
    end

    // Counters, order latch and registered read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt          <= 5'd0;
            rd_cnt          <= 5'd0;
            dec_lat         <= 1'b0;
            bus.rk_rd_valid <= 1'b0;
            bus.rk_rd_data  <= '0;
            bus.rk_rd_idx   <= 5'd0;
        end else if (clear) begin
            wr_cnt          <= 5'd0;
            rd_cnt          <= 5'd0;
            bus.rk_rd_valid <= 1'b0;
        end else begin
            // wr_cnt wraps to 0 on the 32nd accept, leaving it ready for
            // the next load after a clear.
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 5'd1;
            end
            bus.rk_rd_valid <= rd_fire;
            if (rd_fire) begin
                bus.rk_rd_idx  <= rd_cnt;
                bus.rk_rd_data <= mem[rd_addr];
                rd_cnt         <= rd_cnt + 5'd1;
                if (rd_cnt == 5'd0) begin
                    dec_lat <= bus.dec;
                end
            end
        end
    end

endmodule

// File: tb/tb_sms4_rk_reverse_buf.sv
// tb/tb_sms4_rk_reverse_buf.sv - self-checking bench for sms4_rk_reverse_buf

module tb_sms4_rk_reverse_buf;

    logic clk = 1'b0;
    logic rst;
    logic clear;

    always #5 clk = ~clk;

    sms4_rk_reverse_buf_if #(.BWIDTH(32)) bus ();

    sms4_rk_reverse_buf #(.BWIDTH(32), .NROUND(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr_valid;
        logic [31:0] wr_data;
        logic        dec;
        logic        rd_req;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [4:0]  exp_idx;
        logic        exp_loaded;
    } vec_t;

    vec_t vecs [0:128];
    int   nvec;

    // Reference model: key set as a queue, block position and block order.
    logic [31:0] keys [$];
    int          m_pos;
    logic        m_rev;
    logic        m_valid;
    logic [31:0] m_data;
    logic [4:0]  m_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wv, input logic [31:0] wd, input logic d,
                                input logic rq, input logic ev, input logic [31:0] ed,
                                input logic [4:0] ei, input logic el);
        vec_t v;
        v.wr_valid   = wv;
        v.wr_data    = wd;
        v.dec        = d;
        v.rd_req     = rq;
        v.exp_valid  = ev;
        v.exp_data   = ed;
        v.exp_idx    = ei;
        v.exp_loaded = el;
        return v;
    endfunction

    task automatic model_reset();
        keys.delete();
        m_pos   = 0;
        m_rev   = 1'b0;
        m_valid = 1'b0;
        m_data  = 32'h0;
        m_idx   = 5'd0;
    endtask

    task automatic drive(input logic clr, input logic wv, input logic [31:0] wd,
                         input logic d, input logic rq);
        clear           = clr;
        bus.rk_wr_valid = wv;
        bus.rk_wr_data  = wd;
        bus.dec         = d;
        bus.rk_rd_req   = rq;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock with the given inputs; model advanced and every output checked.
    task automatic mcycle(input string name, input logic clr, input logic wv,
                          input logic [31:0] wd, input logic d, input logic rq);
        drive(clr, wv, wd, d, rq);
        @(posedge clk);
        if (clr) begin
            keys.delete();
            m_pos   = 0;
            m_valid = 1'b0;
        end else if (keys.size() < 32) begin
            m_valid = 1'b0;
            if (wv) keys.push_back(wd);
        end else begin
            m_valid = rq;
            if (rq) begin
                if (m_pos == 0) m_rev = d;
                m_idx  = 5'(m_pos);
                m_data = m_rev ? keys[31 - m_pos] : keys[m_pos];
                m_pos  = (m_pos + 1) % 32;
            end
        end
        #1;
        chk({name, " valid"},  32'(bus.rk_rd_valid), 32'(m_valid));
        chk({name, " loaded"}, 32'(bus.loaded),      32'(keys.size() == 32));
        chk({name, " wr_rdy"}, 32'(bus.rk_wr_ready), 32'(keys.size() != 32));
        chk({name, " data"},   32'(bus.rk_rd_data),  m_data);
        chk({name, " idx"},    32'(bus.rk_rd_idx),   32'(m_idx));
    endtask

    initial begin
        // Vector table: ordered load, forward read, reverse read, order latch + wrap.
        nvec = 0;
        for (int i = 0; i < 32; i++) begin
            vecs[nvec] = mk(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'(i == 31));
            nvec++;
        end
        for (int i = 0; i < 32; i++) begin
            vecs[nvec] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'(i), 5'(i), 1'b1);
            nvec++;
        end
        for (int i = 0; i < 32; i++) begin
            vecs[nvec] = mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'(31 - i), 5'(i), 1'b1);
            nvec++;
        end
        for (int i = 0; i < 32; i++) begin
            vecs[nvec] = mk(1'b0, 32'h0, 1'(i >= 10), 1'b1, 1'b1, 32'(i), 5'(i), 1'b1);
            nvec++;
        end
        vecs[nvec] = mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h1F, 5'd0, 1'b1);
        nvec++;

        // Reset state, observed before any clock edge
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("rst wr_rdy", 32'(bus.rk_wr_ready), 32'h1);
        chk("rst loaded", 32'(bus.loaded),      32'h0);
        chk("rst valid",  32'(bus.rk_rd_valid), 32'h0);
        chk("rst data",   32'(bus.rk_rd_data),  32'h0);
        chk("rst idx",    32'(bus.rk_rd_idx),   32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post-rst wr_rdy", 32'(bus.rk_wr_ready), 32'h1);

        for (int k = 0; k < nvec; k++) begin
            drive(1'b0, vecs[k].wr_valid, vecs[k].wr_data, vecs[k].dec, vecs[k].rd_req);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d valid", k),  32'(bus.rk_rd_valid), 32'(vecs[k].exp_valid));
            chk($sformatf("vec%0d loaded", k), 32'(bus.loaded),      32'(vecs[k].exp_loaded));
            chk($sformatf("vec%0d wr_rdy", k), 32'(bus.rk_wr_ready), 32'(!vecs[k].exp_loaded));
            if (vecs[k].exp_valid) begin
                chk($sformatf("vec%0d data", k), 32'(bus.rk_rd_data), vecs[k].exp_data);
                chk($sformatf("vec%0d idx", k),  32'(bus.rk_rd_idx),  32'(vecs[k].exp_idx));
            end
        end

        // Ignored traffic: read during LOAD, write during READY
        do_reset();
        for (int i = 0; i < 5; i++) mcycle("ign wr", 1'b0, 1'b1, 32'(i), 1'b0, 1'b0);
        mcycle("ign rdreq", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("ign rd_valid", 32'(bus.rk_rd_valid), 32'h0);
        for (int i = 5; i < 32; i++) mcycle("ign wr", 1'b0, 1'b1, 32'(i), 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("ign wr_rdy full", 32'(bus.rk_wr_ready), 32'h0);
        mcycle("ign deadbeef", 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        mcycle("ign rd0", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("ign rd0 data", 32'(bus.rk_rd_data), 32'h0);
        chk("ign rd0 idx",  32'(bus.rk_rd_idx),  32'h0);

        // Clear priority over a same-cycle read, then reload with new keys
        mcycle("clr", 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("clr valid",  32'(bus.rk_rd_valid), 32'h0);
        chk("clr loaded", 32'(bus.loaded),      32'h0);
        chk("clr wr_rdy", 32'(bus.rk_wr_ready), 32'h1);
        for (int i = 0; i < 32; i++) mcycle("reload wr", 1'b0, 1'b1, $urandom | 32'h1, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) mcycle("reload rd", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Async reset mid-load: data register holds a nonzero key beforehand
        mcycle("ar clr", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) mcycle("ar wr", 1'b0, 1'b1, 32'h7000 + 32'(i), 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar loaded", 32'(bus.loaded),      32'h0);
        chk("ar valid",  32'(bus.rk_rd_valid), 32'h0);
        chk("ar data",   32'(bus.rk_rd_data),  32'h0);
        chk("ar wr_rdy", 32'(bus.rk_wr_ready), 32'h1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 32; i++) mcycle("ar reload", 1'b0, 1'b1, 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            mcycle("ar fwd", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            chk($sformatf("ar fwd%0d data", i), 32'(bus.rk_rd_data), 32'(i));
        end

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            mcycle($sformatf("rnd%0d", c),
                   1'($urandom_range(0, 59) == 0),
                   1'($urandom_range(0, 3) != 0),
                   $urandom,
                   1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
